// File: rtl/kan_pkg.sv
// Shared types and constants for the KAN weight fetcher: FSM states, AXI AR
// constants and the grid-size helper.
package kan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EMIT  = 2'd2
    } fsm_state_e;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Number of spline weight pages per node: 2**HBITS steps on each side of zero.
    function automatic int grid_size(input int hbits);
        return 2 ** (hbits + 1);
    endfunction

endpackage

// File: rtl/kan_weight_fetcher_if.sv
// Sample stream in, descriptor stream out and AXI read-address channel of the
// weight fetcher; the master modport is the fetcher's view.
interface kan_weight_fetcher_if #(
    parameter int DATAW = 16,
    parameter int ADDRW = 32
);

    logic [DATAW-1:0]   s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tready;

    logic [2*DATAW-1:0] m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tlast;
    logic               m_axis_tready;

    logic [ADDRW-1:0]   m_axi_araddr;
    logic               m_axi_arvalid;
    logic               m_axi_arready;
    logic [7:0]         m_axi_arlen;
    logic [2:0]         m_axi_arsize;
    logic [1:0]         m_axi_arburst;
    logic               rlast_seen;

    modport master (
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output m_axi_araddr, m_axi_arvalid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arready, rlast_seen
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  m_axi_araddr, m_axi_arvalid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arready, rlast_seen
    );

endinterface

// File: rtl/kan_burst_credit.sv
// Outstanding read-burst counter: +1 per issued burst, -1 per completed burst,
// saturating at both ends; full blocks further issue.
module kan_burst_credit #(
    parameter int MAX_OUTST = 8,
    parameter int CW        = $clog2(MAX_OUTST + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full
);

    logic [CW-1:0] count;
    logic          inc_ok;
    logic          dec_ok;

    assign inc_ok = inc && (count != CW'(MAX_OUTST));
    assign dec_ok = dec && (count != '0);
    assign full   = (count >= CW'(MAX_OUTST));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc_ok && !dec_ok) begin
            count <= count + CW'(1);
        end else if (dec_ok && !inc_ok) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/kan_weight_fetcher.sv
// Per input sample: NBASIS spline-weight AR bursts plus one SiLU burst, then a
// {grid_id, x} descriptor downstream. Layer config is latched at node 0.
module kan_weight_fetcher
    import kan_pkg::*;
#(
    parameter int DATAW     = 16,
    parameter int FRAC      = 10,
    parameter int HBITS     = 4,
    parameter int NBASIS    = 4,
    parameter int ADDRW     = 32,
    parameter int PAGE_BITS = 12,
    parameter int LG_LAYER  = 12,
    parameter int MAX_OUTST = 8
) (
    input  logic                s_axis_aclk,
    input  logic                s_axis_areset,
    input  logic [ADDRW-1:0]    base_addr,
    input  logic [ADDRW-1:0]    zero_addr,
    input  logic [LG_LAYER-1:0] inp_layer_size,
    input  logic [LG_LAYER-1:0] out_layer_size,
    kan_weight_fetcher_if.master bus
);

    localparam int GRID_SIZE = grid_size(HBITS);
    localparam int PW        = ADDRW - PAGE_BITS;
    localparam int BIW       = $clog2(NBASIS + 1);
    localparam int SHIFT     = FRAC - HBITS;

    fsm_state_e          state_q, state_d;
    logic                alive_q;
    logic [DATAW-1:0]    x_q;
    logic [DATAW:0]      grid_q;
    logic [PW-1:0]       node_page_q;
    logic [ADDRW-1:0]    zero_q;
    logic [LG_LAYER-1:0] inp_size_q;
    logic [LG_LAYER-1:0] node_cnt_q;
    logic [7:0]          arlen_q;
    logic [BIW-1:0]      burst_idx_q;

    logic                s_hs, ar_hs, m_hs;
    logic                last_burst, last_node, layer_start, credit_full;
    logic signed [DATAW:0] x_ext, x_sh;
    logic [DATAW:0]      grid_d;
    logic [DATAW+1:0]    gk;
    logic                in_range;
    logic [PW-1:0]       page;
    logic [ADDRW-1:0]    addr_calc;

    assign s_hs        = bus.s_axis_tvalid && bus.s_axis_tready;
    assign ar_hs       = bus.m_axi_arvalid && bus.m_axi_arready;
    assign m_hs        = bus.m_axis_tvalid && bus.m_axis_tready;
    assign last_burst  = (burst_idx_q == BIW'(NBASIS));
    assign last_node   = (node_cnt_q == inp_size_q - LG_LAYER'(1));
    assign layer_start = (node_cnt_q == '0);

    // Shift kept separate from the offset add so it stays arithmetic.
    assign x_ext  = {bus.s_axis_tdata[DATAW-1], bus.s_axis_tdata};
    assign x_sh   = x_ext >>> SHIFT;
    assign grid_d = x_sh + (DATAW+1)'(GRID_SIZE / 2);

    assign gk       = {grid_q[DATAW], grid_q} + (DATAW+2)'(burst_idx_q);
    assign in_range = !gk[DATAW+1] && (gk < (DATAW+2)'(GRID_SIZE));

    always_comb begin
        page = node_page_q + PW'(GRID_SIZE);
        if (!last_burst) begin
            page = node_page_q + PW'(gk);
        end
    end

    assign addr_calc = (!last_burst && !in_range) ? zero_q : {page, {PAGE_BITS{1'b0}}};

    kan_burst_credit #(
        .MAX_OUTST(MAX_OUTST)
    ) u_credit (
        .clk  (s_axis_aclk),
        .rst  (s_axis_areset),
        .inc  (ar_hs),
        .dec  (bus.rlast_seen),
        .full (credit_full)
    );

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable written in a combinational process gets a default
    // first; otherwise an unassigned path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (s_hs) state_d = ST_ISSUE;
            ST_ISSUE: if (ar_hs && last_burst) state_d = ST_EMIT;
            ST_EMIT:  if (m_hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // arvalid can only fall via a handshake: credits only drop while it waits.
    always_comb begin
        bus.s_axis_tready = 1'b0;
        bus.m_axi_arvalid = 1'b0;
        bus.m_axi_araddr  = '0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        case (state_q)
            ST_IDLE:  bus.s_axis_tready = alive_q;
            ST_ISSUE: begin
                bus.m_axi_arvalid = !credit_full;
                bus.m_axi_araddr  = addr_calc;
            end
            ST_EMIT: begin
                bus.m_axis_tvalid = 1'b1;
                bus.m_axis_tlast  = last_node;
            end
            default: ;
        endcase
    end

    assign bus.m_axis_tdata  = {grid_q[DATAW-1:0], x_q};
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = AXI_SIZE_8B;
    assign bus.m_axi_arburst = AXI_BURST_INCR;

    // alive_q keeps tready low for the first cycle after reset is released.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            alive_q     <= 1'b0;
            x_q         <= '0;
            grid_q      <= '0;
            node_page_q <= '0;
            zero_q      <= '0;
            inp_size_q  <= '0;
            node_cnt_q  <= '0;
            arlen_q     <= '0;
            burst_idx_q <= '0;
        end else begin
            alive_q <= 1'b1;
            if (s_hs) begin
                x_q    <= bus.s_axis_tdata;
                grid_q <= grid_d;
                if (layer_start) begin
                    node_page_q <= PW'(base_addr >> PAGE_BITS);
                    zero_q      <= zero_addr;
                    inp_size_q  <= inp_layer_size;
                    arlen_q     <= 8'((out_layer_size >> 2) - 1);
                end
            end
            if (ar_hs) begin
                if (last_burst) begin
                    burst_idx_q <= '0;
                    node_page_q <= node_page_q + PW'(GRID_SIZE + 1);
                end else begin
                    burst_idx_q <= burst_idx_q + BIW'(1);
                end
            end
            if (m_hs) begin
                node_cnt_q <= last_node ? '0 : node_cnt_q + LG_LAYER'(1);
            end
        end
    end

endmodule
